// File: rtl/cr_branch_resolve_pkg.sv
// Shared types and constants for the CR read-side branch resolution path.
// Sits beside the CR width and ALU-op definitions used by the EX stage.
package cr_branch_resolve_pkg;

  localparam int unsigned CR_WIDTH = 32;
  localparam int unsigned BI_WIDTH = 5;
  localparam int unsigned ADDR_W   = 32;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'd0,
    ALU_SUB  = 3'd1,
    ALU_AND  = 3'd2,
    ALU_OR   = 3'd3,
    ALU_XOR  = 3'd4,
    ALU_CMP  = 3'd5,
    ALU_CMPL = 3'd6,
    ALU_NOP  = 3'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    BR_KIND_BC  = 2'd0,
    BR_KIND_LR  = 2'd1,
    BR_KIND_CTR = 2'd2,
    BR_KIND_RSV = 2'd3
  } br_kind_e;

  // BO is numbered MSB-first: BO[0] lives at LSB index 4.
  localparam int unsigned BO_COND_IGN = 4;
  localparam int unsigned BO_COND_VAL = 3;
  localparam int unsigned BO_NO_DEC   = 2;
  localparam int unsigned BO_CTR_ZERO = 1;
  localparam int unsigned BO_HINT     = 0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } br_state_e;

endpackage

// File: rtl/cr_branch_resolve_br_cond_eval.sv
// Combinational BO rule evaluation: CTR decrement/test and CR bit test.
module br_cond_eval
  import cr_branch_resolve_pkg::*;
#(
  parameter int unsigned AW = ADDR_W
) (
  input  logic [4:0]    bo,
  input  logic          cr_bit,
  input  logic [AW-1:0] ctr,
  output logic          ctr_ok,
  output logic          cond_ok,
  output logic          dec,
  output logic [AW-1:0] ctr_n
);

  // The static prediction hint has no effect on resolution.
  logic hint_unused;

  always_comb begin
    hint_unused = bo[BO_HINT];
    dec         = !bo[BO_NO_DEC];
    ctr_n       = ctr - AW'(1);
    ctr_ok      = bo[BO_NO_DEC] | ((ctr_n != '0) ^ bo[BO_CTR_ZERO]);
    cond_ok     = bo[BO_COND_IGN] | (cr_bit == bo[BO_COND_VAL]);
  end

endmodule

// File: rtl/cr_branch_resolve.sv
// Conditional branch resolution against the CR, with CTR ownership.
// Waits out in-flight CR writes, then reports taken/target/link registered.
module cr_branch_resolve
  import cr_branch_resolve_pkg::*;
#(
  parameter int unsigned CR_W = CR_WIDTH,
  parameter int unsigned BI_W = BI_WIDTH,
  parameter int unsigned AW   = ADDR_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [CR_W-1:0] cr_rd,
  input  logic            cr_busy,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [4:0]      req_bo,
  input  logic [BI_W-1:0] req_bi,
  input  logic [1:0]      req_kind,
  input  logic            req_lk,
  input  logic [AW-1:0]   req_pc,
  input  logic [AW-1:0]   req_tgt,
  input  logic [AW-1:0]   lr_rd,
  input  logic            flush,
  input  logic            ctr_we,
  input  logic [AW-1:0]   ctr_wd,
  output logic [AW-1:0]   ctr_rd,
  output logic            res_valid,
  output logic            res_taken,
  output logic [AW-1:0]   res_target,
  output logic            res_lr_we,
  output logic [AW-1:0]   res_lr_wd
);

  br_state_e       state_q, state_d;
  logic [4:0]      bo_q, bo_d;
  logic [BI_W-1:0] bi_q, bi_d;
  br_kind_e        kind_q, kind_d;
  logic            lk_q, lk_d;
  logic [AW-1:0]   pc_q, pc_d;
  logic [AW-1:0]   tgt_q, tgt_d;
  logic [AW-1:0]   ctr_q, ctr_d;

  logic            res_valid_q, res_valid_d;
  logic            res_taken_q, res_taken_d;
  logic [AW-1:0]   res_target_q, res_target_d;
  logic            res_lr_we_q, res_lr_we_d;
  logic [AW-1:0]   res_lr_wd_q, res_lr_wd_d;

  logic            use_held;
  logic [4:0]      ev_bo, bo_eff;
  logic [BI_W-1:0] ev_bi, cr_idx;
  br_kind_e        ev_kind;
  logic            ev_lk;
  logic [AW-1:0]   ev_pc, ev_tgt, tgt_sel;
  logic            cr_bit;
  logic            ctr_ok, cond_ok, dec;
  logic [AW-1:0]   ctr_n;
  logic            accept, eval_fire;

  // Accept-cycle evaluation reads the live request; WAIT reads the held copy.
  always_comb begin
    use_held = (state_q == ST_WAIT);
    ev_bo    = use_held ? bo_q   : req_bo;
    ev_bi    = use_held ? bi_q   : req_bi;
    ev_kind  = use_held ? kind_q : br_kind_e'(req_kind);
    ev_lk    = use_held ? lk_q   : req_lk;
    ev_pc    = use_held ? pc_q   : req_pc;
    ev_tgt   = use_held ? tgt_q  : req_tgt;

    // bcctr cannot decrement the register it jumps through; reserved never decrements.
    bo_eff = ev_bo;
    if (ev_kind == BR_KIND_CTR || ev_kind == BR_KIND_RSV) begin
      bo_eff[BO_NO_DEC] = 1'b1;
    end

    cr_idx = BI_W'(CR_W - 1) - ev_bi;
    cr_bit = cr_rd[cr_idx];

    case (ev_kind)
      BR_KIND_LR:  tgt_sel = lr_rd;
      BR_KIND_CTR: tgt_sel = ctr_q;
      default:     tgt_sel = ev_tgt;
    endcase
  end

  br_cond_eval #(
    .AW (AW)
  ) u_cond (
    .bo      (bo_eff),
    .cr_bit  (cr_bit),
    .ctr     (ctr_q),
    .ctr_ok  (ctr_ok),
    .cond_ok (cond_ok),
    .dec     (dec),
    .ctr_n   (ctr_n)
  );

  always_comb begin
    state_d      = state_q;
    bo_d         = bo_q;
    bi_d         = bi_q;
    kind_d       = kind_q;
    lk_d         = lk_q;
    pc_d         = pc_q;
    tgt_d        = tgt_q;
    ctr_d        = ctr_q;
    res_valid_d  = 1'b0;
    res_taken_d  = res_taken_q;
    res_target_d = res_target_q;
    res_lr_we_d  = res_lr_we_q;
    res_lr_wd_d  = res_lr_wd_q;
    accept       = 1'b0;
    eval_fire    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_valid && !flush) begin
          accept = 1'b1;
          if (cr_busy) state_d = ST_WAIT;
          else         eval_fire = 1'b1;
        end
      end
      ST_WAIT: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else if (!cr_busy) begin
          eval_fire = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (accept) begin
      bo_d   = req_bo;
      bi_d   = req_bi;
      kind_d = br_kind_e'(req_kind);
      lk_d   = req_lk;
      pc_d   = req_pc;
      tgt_d  = req_tgt;
    end

    if (eval_fire) begin
      res_valid_d  = 1'b1;
      res_taken_d  = ctr_ok & cond_ok & (ev_kind != BR_KIND_RSV);
      res_target_d = tgt_sel & ~AW'(3);
      res_lr_we_d  = ev_lk & (ev_kind != BR_KIND_RSV);
      res_lr_wd_d  = ev_pc + AW'(4);
      if (dec) ctr_d = ctr_n;
    end

    // An mtctr landing with a decrement overrides it.
    if (ctr_we) ctr_d = ctr_wd;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      bo_q         <= '0;
      bi_q         <= '0;
      kind_q       <= BR_KIND_BC;
      lk_q         <= 1'b0;
      pc_q         <= '0;
      tgt_q        <= '0;
      ctr_q        <= '0;
      res_valid_q  <= 1'b0;
      res_taken_q  <= 1'b0;
      res_target_q <= '0;
      res_lr_we_q  <= 1'b0;
      res_lr_wd_q  <= '0;
    end else begin
      state_q      <= state_d;
      bo_q         <= bo_d;
      bi_q         <= bi_d;
      kind_q       <= kind_d;
      lk_q         <= lk_d;
      pc_q         <= pc_d;
      tgt_q        <= tgt_d;
      ctr_q        <= ctr_d;
      res_valid_q  <= res_valid_d;
      res_taken_q  <= res_taken_d;
      res_target_q <= res_target_d;
      res_lr_we_q  <= res_lr_we_d;
      res_lr_wd_q  <= res_lr_wd_d;
    end
  end

  always_comb begin
    req_ready  = (state_q == ST_IDLE) & !rst;
    ctr_rd     = ctr_q;
    res_valid  = res_valid_q;
    res_taken  = res_taken_q;
    res_target = res_target_q;
    res_lr_we  = res_lr_we_q;
    res_lr_wd  = res_lr_wd_q;
  end

endmodule

// File: tb/tb_cr_branch_resolve.sv
// Directed bench for cr_branch_resolve with hand-computed expectations.
module tb_cr_branch_resolve;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cr_rd;
  logic        cr_busy;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_bo;
  logic [4:0]  req_bi;
  logic [1:0]  req_kind;
  logic        req_lk;
  logic [31:0] req_pc;
  logic [31:0] req_tgt;
  logic [31:0] lr_rd;
  logic        flush;
  logic        ctr_we;
  logic [31:0] ctr_wd;
  logic [31:0] ctr_rd;
  logic        res_valid;
  logic        res_taken;
  logic [31:0] res_target;
  logic        res_lr_we;
  logic [31:0] res_lr_wd;

  int tests = 0;
  int fails = 0;

  cr_branch_resolve #(
    .CR_W (32),
    .BI_W (5),
    .AW   (32)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cr_rd      (cr_rd),
    .cr_busy    (cr_busy),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_bo     (req_bo),
    .req_bi     (req_bi),
    .req_kind   (req_kind),
    .req_lk     (req_lk),
    .req_pc     (req_pc),
    .req_tgt    (req_tgt),
    .lr_rd      (lr_rd),
    .flush      (flush),
    .ctr_we     (ctr_we),
    .ctr_wd     (ctr_wd),
    .ctr_rd     (ctr_rd),
    .res_valid  (res_valid),
    .res_taken  (res_taken),
    .res_target (res_target),
    .res_lr_we  (res_lr_we),
    .res_lr_wd  (res_lr_wd)
  );

  always #5 clk = ~clk;

  // Issue logic must never pair mtctr with an accepted decrementing branch.
  always @(posedge clk) begin
    if (!rst) begin
      assert (!(ctr_we && req_valid && req_ready && !flush && !cr_busy &&
                !req_bo[2] && (req_kind == 2'd0 || req_kind == 2'd1)))
      else $error("FAIL ctr_collision: mtctr and CTR decrement in same cycle");
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] bo, input logic [4:0] bi, input logic [1:0] kind,
                       input logic lk, input logic [31:0] pc, input logic [31:0] tgt);
    req_valid = 1'b1;
    req_bo    = bo;
    req_bi    = bi;
    req_kind  = kind;
    req_lk    = lk;
    req_pc    = pc;
    req_tgt   = tgt;
  endtask

  initial begin
    rst = 1'b1; cr_rd = '0; cr_busy = 1'b0; req_valid = 1'b0; req_bo = '0;
    req_bi = '0; req_kind = '0; req_lk = 1'b0; req_pc = '0; req_tgt = '0;
    lr_rd = '0; flush = 1'b0; ctr_we = 1'b0; ctr_wd = '0;

    #1;
    check("rst_ready", req_ready, 1'b0);
    check("rst_valid", res_valid, 1'b0);
    check("rst_ctr", ctr_rd, 32'h0);
    check("rst_target", res_target, 32'h0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("post_rst_ready", req_ready, 1'b1);

    // bc: branch if CR bit 2 set
    cr_rd = 32'h2000_0000;
    issue(5'b01100, 5'd2, 2'd0, 1'b0, 32'h80, 32'h100);
    tick();
    req_valid = 1'b0;
    check("bc_valid", res_valid, 1'b1);
    check("bc_taken", res_taken, 1'b1);
    check("bc_target", res_target, 32'h100);
    check("bc_lr_we", res_lr_we, 1'b0);
    check("bc_lr_wd", res_lr_wd, 32'h84);
    check("bc_ctr", ctr_rd, 32'h0);
    tick();
    check("bc_pulse", res_valid, 1'b0);
    check("bc_hold_target", res_target, 32'h100);

    // Same bc with the CR bit clear
    cr_rd = 32'hDFFF_FFFF;
    issue(5'b01100, 5'd2, 2'd0, 1'b0, 32'h80, 32'h100);
    tick();
    req_valid = 1'b0;
    check("bc_nt_valid", res_valid, 1'b1);
    check("bc_nt_taken", res_taken, 1'b0);

    // bdnz loop, back-to-back
    ctr_we = 1'b1; ctr_wd = 32'd3;
    tick();
    ctr_we = 1'b0;
    check("mtctr3", ctr_rd, 32'd3);
    issue(5'b10000, 5'd0, 2'd0, 1'b0, 32'h2F0, 32'h300);
    tick();
    check("bdnz1_valid", res_valid, 1'b1);
    check("bdnz1_taken", res_taken, 1'b1);
    check("bdnz1_ctr", ctr_rd, 32'd2);
    check("bdnz1_ready", req_ready, 1'b1);
    tick();
    check("bdnz2_valid", res_valid, 1'b1);
    check("bdnz2_taken", res_taken, 1'b1);
    check("bdnz2_ctr", ctr_rd, 32'd1);
    tick();
    req_valid = 1'b0;
    check("bdnz3_valid", res_valid, 1'b1);
    check("bdnz3_taken", res_taken, 1'b0);
    check("bdnz3_ctr", ctr_rd, 32'd0);

    // bclrl, always taken
    lr_rd = 32'h400;
    issue(5'b10100, 5'd0, 2'd1, 1'b1, 32'h200, 32'hBEEF);
    tick();
    req_valid = 1'b0;
    check("bclr_taken", res_taken, 1'b1);
    check("bclr_target", res_target, 32'h400);
    check("bclr_lr_we", res_lr_we, 1'b1);
    check("bclr_lr_wd", res_lr_wd, 32'h204);
    check("bclr_ctr", ctr_rd, 32'd0);

    // bcctr with decrementing BO: no decrement, target aligned from CTR
    ctr_we = 1'b1; ctr_wd = 32'h1237;
    tick();
    ctr_we = 1'b0;
    issue(5'b10000, 5'd0, 2'd2, 1'b0, 32'h300, 32'hDEAD);
    tick();
    req_valid = 1'b0;
    check("bcctr_taken", res_taken, 1'b1);
    check("bcctr_target", res_target, 32'h1234);
    check("bcctr_ctr", ctr_rd, 32'h1237);

    // Reserved kind: never taken, no link, no decrement
    issue(5'b10000, 5'd0, 2'd3, 1'b1, 32'h310, 32'h320);
    tick();
    req_valid = 1'b0;
    check("rsv_valid", res_valid, 1'b1);
    check("rsv_taken", res_taken, 1'b0);
    check("rsv_lr_we", res_lr_we, 1'b0);
    check("rsv_ctr", ctr_rd, 32'h1237);

    // CR hazard: busy three cycles, CR bit 5 arrives during the wait
    cr_rd = 32'h0; cr_busy = 1'b1;
    issue(5'b01100, 5'd5, 2'd0, 1'b0, 32'h600, 32'h500);
    tick();
    req_valid = 1'b0;
    check("haz_ready", req_ready, 1'b0);
    check("haz_wait1", res_valid, 1'b0);
    cr_rd = 32'h0400_0000;
    tick();
    check("haz_wait2", res_valid, 1'b0);
    tick();
    check("haz_wait3", res_valid, 1'b0);
    cr_busy = 1'b0;
    tick();
    check("haz_valid", res_valid, 1'b1);
    check("haz_taken", res_taken, 1'b1);
    check("haz_target", res_target, 32'h500);
    check("haz_ready_back", req_ready, 1'b1);
    tick();
    check("haz_pulse", res_valid, 1'b0);

    // Flush in WAIT
    ctr_we = 1'b1; ctr_wd = 32'd5;
    tick();
    ctr_we = 1'b0;
    cr_busy = 1'b1;
    issue(5'b10000, 5'd0, 2'd0, 1'b0, 32'h800, 32'h900);
    tick();
    req_valid = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    cr_busy = 1'b0;
    check("flw_valid", res_valid, 1'b0);
    check("flw_ready", req_ready, 1'b1);
    tick();
    check("flw_no_late", res_valid, 1'b0);
    check("flw_ctr", ctr_rd, 32'd5);

    // Flush in the evaluate cycle of a held bdnz
    cr_busy = 1'b1;
    issue(5'b10000, 5'd0, 2'd0, 1'b0, 32'h800, 32'h900);
    tick();
    req_valid = 1'b0;
    cr_busy = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fle_valid", res_valid, 1'b0);
    check("fle_ctr", ctr_rd, 32'd5);
    check("fle_ready", req_ready, 1'b1);

    // Flush beats req_valid in IDLE
    issue(5'b10000, 5'd0, 2'd0, 1'b0, 32'h800, 32'h900);
    flush = 1'b1;
    tick();
    req_valid = 1'b0;
    flush = 1'b0;
    check("fli_valid", res_valid, 1'b0);
    check("fli_ctr", ctr_rd, 32'd5);

    // Normal request afterwards
    issue(5'b10000, 5'd0, 2'd0, 1'b0, 32'h700, 32'h710);
    tick();
    req_valid = 1'b0;
    check("post_fl_valid", res_valid, 1'b1);
    check("post_fl_taken", res_taken, 1'b1);
    check("post_fl_target", res_target, 32'h710);
    check("post_fl_lr_wd", res_lr_wd, 32'h704);
    check("post_fl_ctr", ctr_rd, 32'd4);

    // Async reset mid-WAIT
    cr_busy = 1'b1;
    issue(5'b10000, 5'd0, 2'd0, 1'b0, 32'hA00, 32'hB00);
    tick();
    req_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("arst_valid", res_valid, 1'b0);
    check("arst_ctr", ctr_rd, 32'h0);
    check("arst_target", res_target, 32'h0);
    check("arst_lr_wd", res_lr_wd, 32'h0);
    check("arst_ready", req_ready, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cr_busy = 1'b0;
    tick();
    check("arst_no_late1", res_valid, 1'b0);
    check("arst_ready_back", req_ready, 1'b1);
    tick();
    check("arst_no_late2", res_valid, 1'b0);
    check("arst_ctr_hold", ctr_rd, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
